// File: rtl/uart_rx_if.sv
// Parallel/serial signal bundle for the UART receiver.
// slave: the receiver itself; master: line driver, tick source and byte consumer.
interface uart_rx_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic                 baud_rate;
    logic                 rx;
    logic [DATA_BITS-1:0] d_out;
    logic                 rx_done;
    logic                 frame_err;
    logic                 parity_err;

    modport slave (
        input  baud_rate,
        input  rx,
        output d_out,
        output rx_done,
        output frame_err,
        output parity_err
    );

    modport master (
        output baud_rate,
        output rx,
        input  d_out,
        input  rx_done,
        input  frame_err,
        input  parity_err
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling; bytes delivered on d_out with an rx_done strobe.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16
) (
    input logic      clk,
    input logic      rst,
    uart_rx_if.slave bus
);

    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [4:0] {
        StIdle   = 5'b00001,
        StStart  = 5'b00010,
        StData   = 5'b00100,
        StStop   = 5'b01000,
        StParity = 5'b10000
    } state_e;
`else
    typedef enum logic [3:0] {
        StIdle  = 4'b0001,
        StStart = 4'b0010,
        StData  = 4'b0100,
        StStop  = 4'b1000
    } state_e;
`endif

    state_e               state_q, state_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] d_out_q, d_out_d;
    logic                 rx_done_q, rx_done_d;
    logic                 frame_err_q, frame_err_d;
    logic                 err_hold_q, err_hold_d;
    logic                 rx_meta, rx_s;
    logic                 tick_last;
`ifdef UART_RX_PARITY_EN
    logic                 parity_bad_q, parity_bad_d;
    logic                 parity_err_q, parity_err_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= bus.rx;
            rx_s    <= rx_meta;
        end
    end

    assign tick_last = bus.baud_rate && (tick_q == TICK_LAST);

    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        d_out_d     = d_out_q;
        rx_done_d   = 1'b0;
        frame_err_d = 1'b0;
        err_hold_d  = err_hold_q;
`ifdef UART_RX_PARITY_EN
        parity_bad_d = parity_bad_q;
        parity_err_d = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                tick_d = '0;
                // After a framing error the line must go high before a new start can arm.
                if (err_hold_q) begin
                    if (rx_s) err_hold_d = 1'b0;
                end else if (!rx_s) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (bus.baud_rate) begin
                    if (tick_q == TICK_HALF) begin
                        tick_d  = '0;
                        bit_d   = '0;
                        state_d = rx_s ? StIdle : StData;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            StData: begin
                if (tick_last) begin
                    tick_d  = '0;
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + BW'(1);
                    if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end else if (bus.baud_rate) begin
                    tick_d = tick_q + TW'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (tick_last) begin
                    tick_d       = '0;
                    parity_bad_d = ^{shift_q, rx_s};
                    state_d      = StStop;
                end else if (bus.baud_rate) begin
                    tick_d = tick_q + TW'(1);
                end
            end
`endif
            StStop: begin
                if (tick_last) begin
                    tick_d  = '0;
                    state_d = StIdle;
`ifdef UART_RX_PARITY_EN
                    parity_err_d = parity_bad_q;
`endif
                    if (rx_s) begin
                        d_out_d    = shift_q;
                        rx_done_d  = 1'b1;
                        err_hold_d = 1'b0;
                    end else begin
                        frame_err_d = 1'b1;
                        err_hold_d  = 1'b1;
                    end
                end else if (bus.baud_rate) begin
                    tick_d = tick_q + TW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                tick_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            tick_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            d_out_q     <= '0;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
            err_hold_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            d_out_q     <= d_out_d;
            rx_done_q   <= rx_done_d;
            frame_err_q <= frame_err_d;
            err_hold_q  <= err_hold_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_bad_q <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            parity_bad_q <= parity_bad_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign bus.parity_err = parity_err_q;
`else
    assign bus.parity_err = 1'b0;
`endif

    assign bus.d_out     = d_out_q;
    assign bus.rx_done   = rx_done_q;
    assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames at 16 ticks/bit with a tick every 4 clk.
module tb_uart_rx;

    localparam int unsigned BIT_CLK = 64;
`ifdef UART_RX_PARITY_EN
    localparam int unsigned FRAME_BITS = 11;
`else
    localparam int unsigned FRAME_BITS = 10;
`endif
    // Start detect: 2 sync + 1 IDLE clk, then 8 + 16*(frame-1) ticks of 4 clk each.
    localparam int LAT_NOM = 3 + 4 * (8 + 16 * (FRAME_BITS - 1));

    logic clk;
    logic rst;

    uart_rx_if #(.DATA_BITS(8)) bus ();

    uart_rx #(
        .DATA_BITS (8),
        .OVERSAMPLE(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int ferr_cnt = 0;
    int perr_cnt = 0;
    int done_cyc = 0;
    int t0       = 0;
    logic [7:0] d_hist [0:15];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor: counts high cycles, so a stretched strobe shows up as an extra count.
    always @(negedge clk) begin
        if (bus.rx_done) begin
            if (done_cnt < 16) d_hist[done_cnt] <= bus.d_out;
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (bus.frame_err) ferr_cnt <= ferr_cnt + 1;
        if (bus.parity_err) perr_cnt <= perr_cnt + 1;
    end

    initial begin
        bus.baud_rate = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            bus.baud_rate = 1'b1;
            @(negedge clk);
            bus.baud_rate = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n);
        t0 = cyc;
        for (int i = 0; i < n; i++) begin
            bus.rx = bits[i];
            repeat (BIT_CLK) @(negedge clk);
        end
        bus.rx = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop);
        logic [10:0] bits;
        bits = '0;
`ifdef UART_RX_PARITY_EN
        bits[10:0] = {stop, ^data, data, 1'b0};
`else
        bits[9:0] = {stop, data, 1'b0};
`endif
        send_bits(bits, FRAME_BITS);
    endtask

    initial begin
        int lat;
        rst    = 1'b1;
        bus.rx = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        chk("reset_d_out", 32'(bus.d_out), 32'h0);
        chk("reset_rx_done", 32'(bus.rx_done), 32'h0);
        chk("reset_frame_err", 32'(bus.frame_err), 32'h0);
        chk("reset_parity_err", 32'(bus.parity_err), 32'h0);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // 1: single byte and strobe latency
        send_frame(8'hA5, 1'b1);
        repeat (20) @(negedge clk);
        #1;
        chk("t1_done_cnt", 32'(done_cnt), 32'd1);
        chk("t1_byte", 32'(d_hist[0]), 32'hA5);
        chk("t1_d_out", 32'(bus.d_out), 32'hA5);
        chk("t1_no_ferr", 32'(ferr_cnt), 32'd0);
        lat = done_cyc - t0;
        chk("t1_latency_window", 32'(lat >= LAT_NOM - 8 && lat <= LAT_NOM + 6), 32'd1);

        // 2: back-to-back, no idle gap
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        repeat (20) @(negedge clk);
        #1;
        chk("t2_done_cnt", 32'(done_cnt), 32'd3);
        chk("t2_byte0", 32'(d_hist[1]), 32'h00);
        chk("t2_byte1", 32'(d_hist[2]), 32'hFF);

        // 3: 3-tick glitch rejected, then a good frame
        bus.rx = 1'b0;
        repeat (12) @(negedge clk);
        bus.rx = 1'b1;
        repeat (200) @(negedge clk);
        #1;
        chk("t3_glitch_no_done", 32'(done_cnt), 32'd3);
        chk("t3_glitch_no_ferr", 32'(ferr_cnt), 32'd0);
        send_frame(8'h3C, 1'b1);
        repeat (20) @(negedge clk);
        #1;
        chk("t3_done_cnt", 32'(done_cnt), 32'd4);
        chk("t3_byte", 32'(d_hist[3]), 32'h3C);

        // 4: stop bit low -> framing error, d_out held
        send_frame(8'h55, 1'b0);
        repeat (20) @(negedge clk);
        #1;
        chk("t4_ferr_cnt", 32'(ferr_cnt), 32'd1);
        chk("t4_no_done", 32'(done_cnt), 32'd4);
        chk("t4_d_out_held", 32'(bus.d_out), 32'h3C);
        repeat (100) @(negedge clk);
        send_frame(8'h81, 1'b1);
        repeat (20) @(negedge clk);
        #1;
        chk("t4_done_cnt", 32'(done_cnt), 32'd5);
        chk("t4_byte", 32'(d_hist[4]), 32'h81);

        // 5: reset during data bit 4 of 0xF0
        t0 = cyc;
        bus.rx = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            bus.rx = 1'b0;
            repeat (BIT_CLK) @(negedge clk);
        end
        bus.rx = 1'b1;
        repeat (BIT_CLK / 2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t5_async_d_out", 32'(bus.d_out), 32'h0);
        chk("t5_async_rx_done", 32'(bus.rx_done), 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (BIT_CLK * 8) @(negedge clk);
        #1;
        chk("t5_no_done", 32'(done_cnt), 32'd5);
        chk("t5_no_ferr", 32'(ferr_cnt), 32'd1);
        send_frame(8'h12, 1'b1);
        repeat (20) @(negedge clk);
        #1;
        chk("t5_done_cnt", 32'(done_cnt), 32'd6);
        chk("t5_byte", 32'(d_hist[5]), 32'h12);
        chk("t5_d_out", 32'(bus.d_out), 32'h12);

`ifdef UART_RX_PARITY_EN
        // 6: even parity good then bad
        send_bits({1'b1, 1'b1, 8'h07, 1'b0}, 11);
        repeat (20) @(negedge clk);
        #1;
        chk("t6_good_done", 32'(done_cnt), 32'd7);
        chk("t6_good_perr", 32'(perr_cnt), 32'd0);
        send_bits({1'b1, 1'b0, 8'h07, 1'b0}, 11);
        repeat (20) @(negedge clk);
        #1;
        chk("t6_bad_done", 32'(done_cnt), 32'd8);
        chk("t6_bad_perr", 32'(perr_cnt), 32'd1);
        chk("t6_bad_strobes_together", 32'(done_cyc), 32'(done_cyc));
        chk("t6_d_out", 32'(bus.d_out), 32'h07);
`else
        chk("parity_err_tied_low", 32'(perr_cnt), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
